muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer for MUL, MULHU, DIVU and REMU. It performs no full-width arithmetic itself. Every 32-bit add or subtract goes through the shared combinational ALU, one operation per cycle over 32 iterations. The parent execute stage muxes the ALU inputs to this block while `busy_o` is high and stalls the pipeline for that time.

---
 rtl/muldiv_pkg.sv | 8 +
 rtl/muldiv_seq.sv | 84 ++++++++
 tb/tb_muldiv_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide sequencer
package muldiv_pkg;
   typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} op_e;
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam int N_ITER = 32;
endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-iteration shift-add multiplier / restoring divider driving a shared external ALU
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] opa_i,
   input  logic [XLEN-1:0] opb_i,
   input  logic            kill_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      alu_ctrl_o,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic [2:0]      alu_flags_i
);
   state_e          state;
   op_e             op;
   logic [4:0]      cnt;
   logic [XLEN-1:0] hi, lo, b, s, sum, hi_nxt, lo_nxt;
   logic            hi_sel, take, cy, last;
   logic            unused_flags;
   assign op           = op_e'(op_i);
   assign last         = cnt == 5'(N_ITER - 1);
   assign unused_flags = ^alu_flags_i[2:1];
   assign busy_o       = state != S_IDLE;
   assign alu_ctrl_o   = state == S_DIV ? ALU_SUB : ALU_ADD;
   assign alu_a_o      = state == S_MUL ? hi : state == S_DIV ? s : '0;
   assign alu_b_o      = (state == S_MUL || state == S_DIV) ? b : '0;
   // next-iteration values: {hi,lo} is the product register in MUL, {R,Q} in DIV
   always_comb begin
      s      = {hi[XLEN-2:0], lo[XLEN-1]};
      take   = hi[XLEN-1] | alu_flags_i[0];
      sum    = lo[0] ? alu_result_i : hi;
      cy     = lo[0] & (alu_result_i < hi);
      hi_nxt = state == S_DIV ? (take ? alu_result_i : s) : {cy, sum[XLEN-1:1]};
      lo_nxt = state == S_DIV ? {lo[XLEN-2:0], take} : {sum[0], lo[XLEN-1:1]};
   end
   // sequencer FSM with registered result and done pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= S_IDLE;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         b        <= '0;
         hi_sel   <= 1'b0;
         result_o <= '0;
         done_o   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start_i && !kill_i) begin
               hi_sel <= op inside {OP_MULHU, OP_REMU};
               hi     <= '0;
               lo     <= opa_i;
               b      <= opb_i;
               cnt    <= '0;
               state  <= op inside {OP_DIVU, OP_REMU} ? S_DIV : S_MUL;
            end
            S_MUL, S_DIV: if (kill_i) state <= S_IDLE;
            else begin
               hi  <= hi_nxt;
               lo  <= lo_nxt;
               cnt <= cnt + 5'd1;
               if (last) begin
                  result_o <= hi_sel ? hi_nxt : lo_nxt;
                  done_o   <= 1'b1;
                  state    <= S_DONE;
               end
            end
            default: begin
               done_o <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors with a result scoreboard and an external ALU model
module tb_muldiv_seq;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, kill = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] opa = '0, opb = '0;
   logic        busy, done;
   logic [31:0] result, alu_a, alu_b, alu_res;
   logic [4:0]  alu_ctrl;
   logic [2:0]  alu_flags;
   int          checks = 0, errors = 0, cyc = 0, busy_cnt = 0;
   logic [31:0] exp_q[$];
   int          edge_q[$];

   muldiv_seq #(.XLEN(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .opa_i(opa), .opb_i(opb),
      .kill_i(kill), .busy_o(busy), .done_o(done), .result_o(result),
      .alu_ctrl_o(alu_ctrl), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_result_i(alu_res), .alu_flags_i(alu_flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // shared ALU as the parent stage would provide it
   always_comb begin
      alu_res   = alu_ctrl == 5'd1 ? alu_a - alu_b : alu_a + alu_b;
      alu_flags = {alu_res == 32'd0, $signed(alu_a) >= $signed(alu_b), alu_a >= alu_b};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: pop expected result whenever the DUT pulses done
   always @(negedge clk) begin
      if (busy) busy_cnt++;
      else busy_cnt = 0;
      if (done) begin
         if (exp_q.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
         else begin
            chk("result", result, exp_q.pop_front());
            chk("latency", cyc - edge_q.pop_front(), 32'd32);
            chk("busy_cycles", busy_cnt, 32'd33);
         end
      end
   end

   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] bb,
                           input logic [31:0] e, input bit push);
      @(negedge clk);
      start = 1'b1; op = o; opa = a; opb = bb;
      if (push) begin
         exp_q.push_back(e);
         edge_q.push_back(cyc + 1);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] bb,
                      input logic [31:0] e);
      start_op(o, a, bb, e, 1'b1);
      chk("alu_ctrl", {27'd0, alu_ctrl}, {31'd0, o[1]});
      wait_idle();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      rst_n = 1'b1;

      run(2'd0, 32'd7, 32'd6, 32'd42);
      run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      run(2'd2, 32'd100, 32'd7, 32'd14);
      run(2'd3, 32'd100, 32'd7, 32'd2);
      run(2'd2, 32'hFFFFFFFF, 32'h80000000, 32'd1);
      run(2'd3, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF);
      run(2'd2, 32'd5, 32'd0, 32'hFFFFFFFF);
      run(2'd3, 32'd5, 32'd0, 32'd5);

      // kill at iteration 10
      start_op(2'd0, 32'd3, 32'd3, 32'd9, 1'b0);
      repeat (10) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_busy", {31'd0, busy}, 32'd0);
      chk("kill_done", {31'd0, done}, 32'd0);
      chk("kill_result", result, 32'd5);
      repeat (40) @(negedge clk);
      chk("kill_result_held", result, 32'd5);

      // start pulsed mid-operation is ignored
      start_op(2'd2, 32'd100, 32'd7, 32'd14, 1'b1);
      repeat (5) @(negedge clk);
      start = 1'b1; op = 2'd0; opa = 32'd2; opb = 32'd2;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      chk("ignored_start_idle", {31'd0, busy}, 32'd0);

      // kill and start together in IDLE: kill wins
      @(negedge clk);
      start = 1'b1; kill = 1'b1; op = 2'd0; opa = 32'd4; opb = 32'd4;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      chk("kill_start_idle", {31'd0, busy}, 32'd0);

      // asynchronous reset mid-DIV
      start_op(2'd2, 32'd1000, 32'd7, 32'd142, 1'b0);
      repeat (10) @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_result", result, 32'd0);
      chk("async_rst_alu_ctrl", {27'd0, alu_ctrl}, 32'd0);
      chk("async_rst_alu_a", alu_a, 32'd0);
      chk("async_rst_alu_b", alu_b, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(2'd2, 32'd9, 32'd3, 32'd3);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
